// File: rtl/pixel_unpacker.sv
// AXI4-Stream 24bpp sink: unpacks 4 pixels from every 3 32-bit words, tags x/y, checks framing.
// Latency: 1 cycle from word handshake to pix_valid; the fourth pixel of a group comes from the residue.
// Backpressure: a single output register; tready drops while it is held or while the residue pixel is pending.
module pixel_unpacker #(
    parameter int X_SIZE = 640,
    parameter int Y_SIZE = 480
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] in_stream_tdata,
    input  logic [3:0]  in_stream_tkeep,
    input  logic        in_stream_tuser,
    input  logic        in_stream_tlast,
    input  logic        in_stream_tvalid,
    output logic        in_stream_tready,
    output logic [7:0]  pix_r,
    output logic [7:0]  pix_g,
    output logic [7:0]  pix_b,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        frame_done,
    output logic        sof_err,
    output logic        eol_err,
    input  logic        err_clear,
    output logic [15:0] frame_count
);
    localparam int WPL = X_SIZE * 3 / 4;
    localparam int WXW = (WPL > 1) ? $clog2(WPL) : 1;

    typedef enum logic {SEEK_SOF, RUN} state_t;

    state_t           state;
    logic [1:0]       phase;
    logic [23:0]      res;
    logic [WXW-1:0]   word_x;
    logic [9:0]       cur_x;
    logic [8:0]       cur_y;

    logic             load_ok;
    logic             word_hs;
    logic             emit_res;
    logic             use_word;
    logic             load;
    logic             frame_pos;
    logic             sof_evt;
    logic             force0;
    logic [1:0]       eff_ph;
    logic [WXW-1:0]   eff_wx;
    logic [9:0]       eff_x;
    logic [8:0]       eff_y;
    logic             line_end;
    logic             early_eol;
    logic [23:0]      word_pix;
    logic [23:0]      word_res;
    logic [23:0]      new_pix;
    logic [9:0]       new_x;
    logic [8:0]       new_y;
    logic             new_eol;
    logic             unused_tkeep;

    assign unused_tkeep     = ^in_stream_tkeep;
    assign load_ok          = ~pix_valid | pix_ready;
    assign in_stream_tready = (state == SEEK_SOF) | ((phase != 2'd3) & load_ok);
    assign word_hs          = in_stream_tvalid & in_stream_tready;
    assign emit_res         = (state == RUN) & (phase == 2'd3) & load_ok;
    // While seeking, only the start-of-frame word is kept; everything else is dropped.
    assign use_word         = word_hs & ((state == RUN) | in_stream_tuser);
    assign load             = emit_res | use_word;
    assign frame_pos        = (word_x != '0) | (cur_x != '0) | (cur_y != '0);
    assign sof_evt          = word_hs & in_stream_tuser & (state == RUN) & frame_pos;
    assign force0           = in_stream_tuser & ((state == SEEK_SOF) | frame_pos);

    always_comb begin
        eff_ph    = force0 ? 2'd0 : phase;
        eff_wx    = force0 ? '0 : word_x;
        eff_x     = force0 ? '0 : cur_x;
        eff_y     = force0 ? '0 : cur_y;
        line_end  = (eff_wx == WXW'(WPL - 1));
        early_eol = in_stream_tlast & ~line_end;

        word_pix = res;
        word_res = res;
        case (eff_ph)
            2'd0: begin
                word_pix = in_stream_tdata[23:0];
                word_res = {16'd0, in_stream_tdata[31:24]};
            end
            2'd1: begin
                word_pix = {in_stream_tdata[15:0], res[7:0]};
                word_res = {8'd0, in_stream_tdata[31:16]};
            end
            2'd2: begin
                word_pix = {in_stream_tdata[7:0], res[15:0]};
                word_res = in_stream_tdata[31:8];
            end
            default: begin
                word_pix = res;
                word_res = res;
            end
        endcase

        if (emit_res) begin
            new_pix = res;
            new_x   = cur_x;
            new_y   = cur_y;
            new_eol = (cur_x == 10'(X_SIZE - 1));
        end else begin
            new_pix = word_pix;
            new_x   = eff_x;
            new_y   = eff_y;
            new_eol = early_eol | (eff_x == 10'(X_SIZE - 1));
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= SEEK_SOF;
            phase       <= 2'd0;
            res         <= '0;
            word_x      <= '0;
            cur_x       <= '0;
            cur_y       <= '0;
            pix_valid   <= 1'b0;
            pix_r       <= '0;
            pix_g       <= '0;
            pix_b       <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_sof     <= 1'b0;
            pix_eol     <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            sof_err     <= 1'b0;
            eol_err     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (pix_valid && pix_ready && pix_x == 10'(X_SIZE - 1) && pix_y == 9'(Y_SIZE - 1)) begin
                frame_done  <= 1'b1;
                frame_count <= frame_count + 16'd1;
            end

            if (load) begin
                pix_valid             <= 1'b1;
                {pix_r, pix_g, pix_b} <= new_pix;
                pix_x                 <= new_x;
                pix_y                 <= new_y;
                pix_sof               <= (new_x == '0) && (new_y == '0);
                pix_eol               <= new_eol;
                if (new_eol) begin
                    cur_x <= '0;
                    cur_y <= (new_y == 9'(Y_SIZE - 1)) ? 9'd0 : new_y + 9'd1;
                end else begin
                    cur_x <= new_x + 10'd1;
                    cur_y <= new_y;
                end
            end else if (pix_ready) begin
                pix_valid <= 1'b0;
            end

            if (emit_res) begin
                phase <= 2'd0;
            end

            if (use_word) begin
                state <= RUN;
                res   <= word_res;
                // An early tlast abandons whatever bytes remain in the residue.
                if (early_eol) begin
                    phase  <= 2'd0;
                    word_x <= '0;
                end else begin
                    phase  <= eff_ph + 2'd1;
                    word_x <= line_end ? '0 : eff_wx + 1'b1;
                end
            end

            sof_err <= sof_evt | (sof_err & ~err_clear);
            eol_err <= (use_word & (in_stream_tlast != line_end)) | (eol_err & ~err_clear);
        end
    end
endmodule

// File: tb/tb_pixel_unpacker.sv
// Bench for pixel_unpacker: byte-stream reference model feeding a scoreboard of expected pixels.
module tb_pixel_unpacker;
    localparam int XS  = 32;
    localparam int YS  = 120;
    localparam int WPL = XS * 3 / 4;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] in_stream_tdata = '0;
    logic [3:0]  in_stream_tkeep = 4'hF;
    logic        in_stream_tuser = 1'b0;
    logic        in_stream_tlast = 1'b0;
    logic        in_stream_tvalid = 1'b0;
    logic        in_stream_tready;
    logic [7:0]  pix_r, pix_g, pix_b;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        pix_sof, pix_eol, pix_valid;
    logic        pix_ready = 1'b1;
    logic        frame_done, sof_err, eol_err;
    logic        err_clear = 1'b0;
    logic [15:0] frame_count;

    pixel_unpacker #(.X_SIZE(XS), .Y_SIZE(YS)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .in_stream_tdata(in_stream_tdata), .in_stream_tkeep(in_stream_tkeep),
        .in_stream_tuser(in_stream_tuser), .in_stream_tlast(in_stream_tlast),
        .in_stream_tvalid(in_stream_tvalid), .in_stream_tready(in_stream_tready),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_x(pix_x), .pix_y(pix_y),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .frame_done(frame_done), .sof_err(sof_err), .eol_err(eol_err),
        .err_clear(err_clear), .frame_count(frame_count)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [7:0] r, g, b;
        int         x, y;
        bit         sof, eol, fd;
    } pix_t;

    pix_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
    int   gap_pct = 0;
    bit   mon_en = 1'b0;
    bit   fd_pending = 1'b0;
    int   fd_seen = 0;
    int   fd_before = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: each output handshake must match the oldest predicted pixel.
    always @(negedge aclk) begin
        pix_t e;
        if (mon_en) begin
            chk("frame_done", frame_done, fd_pending);
            if (frame_done) fd_seen++;
            fd_pending = 1'b0;
            if (pix_valid && pix_ready) begin
                chk("pix_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("pix_rgb", {pix_r, pix_g, pix_b}, {e.r, e.g, e.b});
                    chk("pix_x", pix_x, e.x);
                    chk("pix_y", pix_y, e.y);
                    chk("pix_sof_eol", {pix_sof, pix_eol}, {e.sof, e.eol});
                    fd_pending = e.fd;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge aclk);
        #1;
        case (rdy_mode)
            0:       pix_ready = 1'b1;
            1:       pix_ready = ($urandom_range(0, 3) != 0);
            default: pix_ready = 1'b0;
        endcase
    endtask

    task automatic send_word(input logic [31:0] d, input logic u, input logic l);
        int n = 0;
        bit acc = 1'b0;
        while (gap_pct != 0 && $urandom_range(0, 99) < gap_pct) cyc();
        in_stream_tdata  = d;
        in_stream_tuser  = u;
        in_stream_tlast  = l;
        in_stream_tvalid = 1'b1;
        while (!acc && n < 2000) begin
            @(negedge aclk);
            acc = in_stream_tready;
            cyc();
            n++;
        end
        in_stream_tvalid = 1'b0;
        if (!acc) chk("tready_timeout", n, 0);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || pix_valid) && n < 5000) begin
            cyc();
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
        cyc();
        cyc();
    endtask

    // Line y as a random byte stream: pixel n is bytes 3n..3n+2 = b,g,r; word k is bytes 4k..4k+3.
    // tl >= 0 puts tlast on word tl; nw < WPL without tlast models a line cut short by a new frame.
    task automatic send_line(input int y, input int nw, input bit u0, input int tl, input int hold_at);
        logic [7:0]  lb [0:4*WPL-1];
        logic [31:0] w;
        pix_t        e;
        bit          early;
        int          npx, nsend;
        for (int i = 0; i < 4 * WPL; i++) lb[i] = 8'($urandom);
        early = (tl >= 0 && tl < WPL - 1);
        if (early)          npx = (4 * tl) / 3 + 1;
        else if (nw == WPL) npx = XS;
        else                npx = (4 * nw) / 3;
        for (int n = 0; n < npx; n++) begin
            e.b   = lb[3*n];
            e.g   = lb[3*n+1];
            e.r   = lb[3*n+2];
            e.x   = n;
            e.y   = y;
            e.sof = (n == 0 && y == 0);
            e.eol = (n == XS - 1) || (early && n == npx - 1);
            e.fd  = (n == XS - 1 && y == YS - 1);
            exp_q.push_back(e);
        end
        nsend = early ? tl + 1 : nw;
        for (int k = 0; k < nsend; k++) begin
            w = {lb[4*k+3], lb[4*k+2], lb[4*k+1], lb[4*k]};
            if (k == hold_at) begin
                int n = 0;
                while (pix_valid && n < 100) begin cyc(); n++; end
                rdy_mode = 2;
                send_word(w, 1'b0, 1'b0);
                in_stream_tdata  = {lb[4*k+7], lb[4*k+6], lb[4*k+5], lb[4*k+4]};
                in_stream_tvalid = 1'b1;
                repeat (20) begin
                    @(negedge aclk);
                    chk("hold_valid", pix_valid, 1);
                    chk("hold_rgb", {pix_r, pix_g, pix_b}, {exp_q[0].r, exp_q[0].g, exp_q[0].b});
                    chk("hold_x", pix_x, exp_q[0].x);
                    chk("hold_tready", in_stream_tready, 0);
                    cyc();
                end
                rdy_mode = 0;
            end else begin
                send_word(w, u0 && k == 0, (k == tl) || (tl < 0 && k == WPL - 1));
            end
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_outputs"}, {pix_valid, pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof, pix_eol,
                                frame_done, sof_err, eol_err, frame_count}, 0);
        chk({tag, "_tready"}, in_stream_tready, 1);
    endtask

    task automatic do_reset(input string tag);
        mon_en  = 1'b0;
        aresetn = 1'b0;
        #1;
        chk_reset(tag);
        exp_q.delete();
        fd_pending = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        cyc();
        mon_en = 1'b1;
    endtask

    function automatic pix_t mk(logic [7:0] r, logic [7:0] g, logic [7:0] b, int x);
        pix_t p;
        p.r = r; p.g = g; p.b = b; p.x = x; p.y = 0;
        p.sof = (x == 0); p.eol = 1'b0; p.fd = 1'b0;
        return p;
    endfunction

    initial begin
        #12;
        chk_reset("por");
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        mon_en  = 1'b1;
        cyc();

        // Words without tuser after reset are swallowed.
        for (int i = 0; i < 4; i++) send_word($urandom, 1'b0, i == 2);
        @(negedge aclk);
        chk("seek_tready", in_stream_tready, 1);
        chk("seek_no_pixel", pix_valid, 0);
        cyc();

        // Known-value group of three words.
        exp_q.push_back(mk(8'h33, 8'h22, 8'h11, 0));
        exp_q.push_back(mk(8'h66, 8'h55, 8'h44, 1));
        exp_q.push_back(mk(8'h99, 8'h88, 8'h77, 2));
        exp_q.push_back(mk(8'hCC, 8'hBB, 8'hAA, 3));
        send_word(32'h44332211, 1'b1, 1'b0);
        send_word(32'h88776655, 1'b0, 1'b0);
        send_word(32'hCCBBAA99, 1'b0, 1'b0);
        @(negedge aclk);
        chk("phase3_tready", in_stream_tready, 0);
        cyc();
        @(negedge aclk);
        chk("phase0_tready", in_stream_tready, 1);
        cyc();
        drain();
        do_reset("rst1");

        // Full frame with random gaps and backpressure.
        gap_pct  = 30;
        rdy_mode = 1;
        fd_seen  = 0;
        for (int y = 0; y < YS; y++) send_line(y, WPL, y == 0, -1, -1);
        drain();
        chk("frame_count_1", frame_count, 1);
        chk("frame_done_once", fd_seen, 1);
        chk("no_errs_frame", {sof_err, eol_err}, 0);

        // Early tlast on word 10 of line 2.
        send_line(0, WPL, 1'b1, -1, -1);
        send_line(1, WPL, 1'b0, -1, -1);
        send_line(2, WPL, 1'b0, 10, -1);
        send_line(3, WPL, 1'b0, -1, -1);
        drain();
        chk("eol_err_set", eol_err, 1);
        chk("sof_err_clear_still", sof_err, 0);

        // New frame starts during line 100.
        for (int y = 4; y < 100; y++) send_line(y, WPL, 1'b0, -1, -1);
        send_line(100, 5, 1'b0, -1, -1);
        fd_before = fd_seen;
        send_line(0, WPL, 1'b1, -1, -1);
        send_line(1, WPL, 1'b0, -1, -1);
        drain();
        chk("sof_err_set", sof_err, 1);
        chk("no_fd_truncated", fd_seen, fd_before);
        chk("frame_count_trunc", frame_count, 1);
        err_clear = 1'b1;
        cyc();
        err_clear = 1'b0;
        @(negedge aclk);
        chk("errs_cleared", {sof_err, eol_err}, 0);
        cyc();

        // Output held for 20 cycles mid-line, then reset with a pixel held.
        gap_pct  = 0;
        rdy_mode = 0;
        send_line(2, 10, 1'b0, -1, 4);
        drain();
        rdy_mode = 2;
        send_word($urandom, 1'b0, 1'b0);
        @(negedge aclk);
        chk("held_before_reset", pix_valid, 1);
        @(posedge aclk);
        #1;
        rdy_mode = 0;
        do_reset("rst_mid");
        for (int i = 0; i < 2; i++) send_word($urandom, 1'b0, 1'b0);
        @(negedge aclk);
        chk("reseek_no_pixel", pix_valid, 0);
        cyc();
        send_line(0, WPL, 1'b1, -1, -1);
        drain();
        chk("post_reset_count", frame_count, 0);
        chk("post_reset_errs", {sof_err, eol_err}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pixel_unpacker.md
Name: pixel_unpacker

Overview:
AXI4-Stream video sink, the receive-side counterpart of the pixel packer. It accepts 24bpp pixels packed into a 32-bit stream (tuser marks start of frame, tlast marks end of line) and unpacks them into one RGB pixel per handshake, tagged with x/y coordinates. It checks framing and resynchronises on errors. It sits at the far end of the video stream for loopback and self-check, and feeds capture/compare logic.

Parameters:
X_SIZE, 640, pixels per line; must be a multiple of 4.
Y_SIZE, 480, lines per frame.
WPL, X_SIZE*3/4 (derived localparam), words per line.

Ports:
aclk  in  1  clock
aresetn  in  1  reset, asynchronous assert, active-low
in_stream_tdata  in  32  packed pixel bytes
in_stream_tkeep  in  4  ignored (always 4'hF by protocol)
in_stream_tuser  in  1  start of frame
in_stream_tlast  in  1  end of line
in_stream_tvalid  in  1  word valid
in_stream_tready  out  1  word accepted when tvalid&tready
pix_r, pix_g, pix_b  out  8 each  unpacked pixel
pix_x  out  10  pixel column
pix_y  out  9  pixel row
pix_sof  out  1  pixel is (0,0)
pix_eol  out  1  last pixel of line
pix_valid  out  1  output pixel valid
pix_ready  in  1  downstream accepts pixel
frame_done  out  1  one-cycle pulse on handshake of pixel (X_SIZE-1, Y_SIZE-1)
sof_err  out  1  sticky: unexpected tuser seen
eol_err  out  1  sticky: tlast early or missing
err_clear  in  1  synchronous clear of sof_err/eol_err
frame_count  out  16  completed frames, wraps at 0xFFFF->0

Behaviour:
- Reset: all outputs 0, state SEEK_SOF, phase 0, x=y=word_x=0, residue empty.
- Byte order: line byte stream bytes 3n,3n+1,3n+2 = b,g,r of pixel n. Word k carries bytes 4k..4k+3, with byte 4k in tdata[7:0].
- Phase FSM (byte residue R), applied on word acceptance:
  - Phase 0: pixel = word[23:0]; R = word[31:24]; go to phase 1.
  - Phase 1: pixel = {word[15:0], R}; R = word[31:16]; go to phase 2.
  - Phase 2: pixel = {word[7:0], R[15:0]}; R = word[31:8]; go to phase 3.
  - Phase 3: no word consumed; pixel = R[23:0]; go to phase 0.
- Output is a single register. pix_valid holds with data stable until pix_ready.
- tready = (state==SEEK_SOF) | ((phase!=3) & (!pix_valid | pix_ready)).
- Full throughput: 4 pixels per 3 accepted words. Latency from word handshake to pix_valid is 1 cycle.
- States:
  - SEEK_SOF: tready=1. Words are dropped until tuser=1 is accepted. That word is processed as word 0 of line 0, and the state goes to RUN.
  - RUN: normal unpacking.
- Counters: word_x increments per accepted word. x/y advance per pixel handshake; x wraps at X_SIZE-1 to 0 and y increments, y wraps at Y_SIZE-1 to 0.
  - frame_done pulses on the handshake of pixel (X_SIZE-1, Y_SIZE-1).
  - frame_count increments on the same handshake.
- tuser=1 in RUN with (word_x!=0 | y!=0 | x!=0):
  - set sof_err;
  - discard R, force phase 0;
  - process the word as word 0 of line 0; the resulting pixel has x=0, y=0, pix_sof=1;
  - no frame_done for the truncated frame.
- tlast=1 with word_x!=WPL-1:
  - set eol_err;
  - emit the pixel formed by this word;
  - discard remaining R, force phase 0, word_x=0;
  - that pixel carries pix_eol=1, and the next pixel goes to x=0, y+1.
- tlast=0 with word_x==WPL-1: set eol_err; line wraps exactly as if tlast were present.
- tuser and tlast on the same word: tuser handling first, then tlast handling.
- err_clear and an error event in the same cycle: the flag is set (set wins).
- Reset mid-operation: immediate return to reset values. The held pixel is lost and the state is SEEK_SOF.

Test Plan:
1. Words 0x44332211, 0x88776655, 0xCCBBAA99 (first with tuser=1), pix_ready=1 -> pixels (r,g,b) = (33,22,11) at x0 with sof=1, (66,55,44) x1, (99,88,77) x2, (CC,BB,AA) x3; tready low exactly in the phase-3 cycle.
2. Full 640x480 frame, tlast on every 480th word, random tvalid and pix_ready -> 307200 pixels, x/y sequence correct, frame_done pulses once, frame_count=1, no error flags.
3. Words with tuser=0 after reset -> dropped with tready=1 and no pix_valid until the first tuser word.
4. tlast on word_x=10 of line 2 -> eol_err=1; the pixel from that word has eol=1; the next pixel has x=0, y=3.
5. tuser at line 100 -> sof_err=1; next pixel at (0,0) with sof=1; no frame_done; err_clear then returns both flags to 0.
6. pix_ready held low for 20 cycles mid-line -> pixel held stable, tready=0, no data loss; aresetn pulsed mid-line -> all outputs 0 and SEEK_SOF re-entered.
